// File: rtl/mc_core_param.sv
// Parametrised multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT control with NZCV flags,
// per-instruction condition codes and a ready-handshaked memory port.
module mc_core_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int unsigned IDX_W = $clog2(REG_CNT);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
    typedef enum logic [1:0] {ClsAlu = 2'b00, ClsMem = 2'b01, ClsBr = 2'b10, ClsHalt = 2'b11} cls_e;

    state_e state_q, state_d;
    logic [31:0]       ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] a_q, b_q, op2_q, res_q, mdr_q;
    logic [DATA_W-1:0] regs_q [REG_CNT];

    logic [3:0]  cond, op, rn, rd, rm;
    logic [1:0]  cls;
    logic        imm_bit, s_bit, l_bit, link_bit;
    logic [DATA_W-1:0] imm_ext, off_ext;

    assign cond     = ir_q[31:28];
    assign cls      = ir_q[27:26];
    assign imm_bit  = ir_q[25];
    assign op       = ir_q[24:21];
    assign link_bit = ir_q[24];
    assign s_bit    = ir_q[20];
    assign l_bit    = ir_q[20];
    assign rn       = ir_q[19:16];
    assign rd       = ir_q[15:12];
    assign rm       = ir_q[3:0];
    assign imm_ext  = {{(DATA_W-12){ir_q[11]}}, ir_q[11:0]};
    assign off_ext  = {{(DATA_W-24){ir_q[23]}}, ir_q[23:0]};

    // Indices beyond the implemented file read as zero.
    function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
        rd_reg = '0;
        if (32'(idx) < REG_CNT) rd_reg = regs_q[idx[IDX_W-1:0]];
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: cond_ok = z;
            4'h1: cond_ok = !z;
            4'h2: cond_ok = cf;
            4'h3: cond_ok = !cf;
            4'h4: cond_ok = n;
            4'h5: cond_ok = !n;
            4'h6: cond_ok = v;
            4'h7: cond_ok = !v;
            4'h8: cond_ok = cf && !z;
            4'h9: cond_ok = !cf || z;
            4'hA: cond_ok = (n == v);
            4'hB: cond_ok = (n != v);
            4'hC: cond_ok = !z && (n == v);
            4'hD: cond_ok = z || (n != v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    endfunction

    logic [DATA_W:0]   sum_w, diff_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, flag_wr, alu_no_wb;

    assign sum_w  = {1'b0, a_q} + {1'b0, op2_q};
    assign diff_w = {1'b0, a_q} - {1'b0, op2_q};
    assign alu_no_wb = (op == 4'd6) || op[3];

    always_comb begin
        alu_res = '0;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        flag_wr = (op == 4'd6) || (s_bit && !op[3]);
        case (op)
            4'd0: begin
                alu_res = sum_w[DATA_W-1:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (a_q[DATA_W-1] == op2_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd1, 4'd6: begin
                alu_res = diff_w[DATA_W-1:0];
                alu_c   = !diff_w[DATA_W];
                alu_v   = (a_q[DATA_W-1] != op2_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd2: alu_res = a_q & op2_q;
            4'd3: alu_res = a_q | op2_q;
            4'd4: alu_res = a_q ^ op2_q;
            4'd5: alu_res = op2_q;
            4'd7: alu_res = ~op2_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (!cond_ok(cond, flags_q)) state_d = StFetch;
                else if (cls == ClsHalt)     state_d = StHalt;
                else                         state_d = StExec;
            end
            StExec: begin
                case (cls)
                    ClsAlu:  state_d = alu_no_wb ? StFetch : StWb;
                    ClsMem:  state_d = StMem;
                    default: state_d = StFetch;
                endcase
            end
            StMem:    if (mem_ready) state_d = l_bit ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        if (state_q == StMem) mem_addr = res_q[ADDR_W-1:0];
        if (!reset) begin
            if (state_q == StFetch) mem_re = 1'b1;
            if (state_q == StMem) begin
                mem_re = l_bit;
                mem_we = !l_bit;
            end
        end
    end

    assign mem_wdata = b_q;
    assign flags     = flags_q;
    assign pc        = pc_q;
    assign halted    = (state_q == StHalt);

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            flags_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            mdr_q   <= '0;
            for (int unsigned i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata[31:0];
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end
                StDecode: begin
                    a_q   <= rd_reg(rn);
                    b_q   <= (cls == ClsMem && !l_bit) ? rd_reg(rd) : rd_reg(rm);
                    op2_q <= (cls == ClsMem || imm_bit) ? imm_ext : rd_reg(rm);
                end
                StExec: begin
                    case (cls)
                        ClsAlu: begin
                            res_q <= alu_res;
                            if (flag_wr) flags_q <= {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
                        end
                        ClsMem: res_q <= sum_w[DATA_W-1:0];
                        ClsBr: begin
                            // pc already points past the branch, which is the link value.
                            pc_q <= pc_q + off_ext[ADDR_W-1:0];
                            if (link_bit) regs_q[REG_CNT-1] <= DATA_W'(pc_q);
                        end
                        default: ;
                    endcase
                end
                StMem: if (mem_ready && l_bit) mdr_q <= mem_rdata;
                StWb: begin
                    if (32'(rd) < REG_CNT)
                        regs_q[rd[IDX_W-1:0]] <= (cls == ClsMem) ? mdr_q : res_q;
                end
                default: ;
            endcase
        end
    end
endmodule
